// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. A single FA_str full-adder cell is sequenced
// over WIDTH clock cycles, LSB first, to form a_in + b_in + c_in. The block
// owns the operand shift registers, the carry flop, the bit counter and the
// start/done handshake.
//
// Ports
//   clk      : system clock, rising edge active
//   rst      : synchronous, active-high reset (clears state and results)
//   start    : request pulse, honoured only while idle
//   a_in     : operand A, captured on the accepting edge
//   b_in     : operand B, captured on the accepting edge
//   c_in     : initial carry, captured on the accepting edge
//   busy     : high while bits are being added
//   done     : one-cycle pulse, sum_out/c_out valid from this cycle on
//   sum_out  : WIDTH-bit result, holds the last completed addition
//   c_out    : final carry-out, holds the last completed addition
// -----------------------------------------------------------------------------

// 1-bit full adder: the only arithmetic element of the serial adder.
module FA_str (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   logic p;

   assign p     = a ^ b;
   assign sum   = p ^ c_in;
   assign c_out = (a & b) | (c_in & p);

endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             c_out
);

   localparam int                CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic             carry;
   logic [CNT_W-1:0] count;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] s_next;

   // Shift v right by one and place b in the MSB. Written with shifts so it
   // stays legal for WIDTH == 1, where it simply returns b.
   function automatic logic [WIDTH-1:0] shift_in_msb(input logic [WIDTH-1:0] v,
                                                     input logic             b);
      return (v >> 1) | (WIDTH'(b) << (WIDTH - 1));
   endfunction

   FA_str u_fa (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c_in  (carry),
      .sum   (fa_sum),
      .c_out (fa_cout)
   );

   // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB result.
   assign s_next = shift_in_msb(s_sh, fa_sum);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         carry   <= 1'b0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum_out <= '0;
         c_out   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a_in;
                  b_sh  <= b_in;
                  s_sh  <= '0;
                  carry <= c_in;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end

            ST_RUN: begin
               s_sh  <= s_next;
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= fa_cout;
               count <= count + 1'b1;
               // Last bit: publish the full result in one step so the
               // outputs never expose a partially shifted sum.
               if (count == LAST) begin
                  sum_out <= s_next;
                  c_out   <= fa_cout;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl. Three builds run side by side on one
// clock: WIDTH=8 for the directed vectors, WIDTH=4 and WIDTH=1 for the
// exhaustive back-to-back sweeps against a behavioural a+b+c model.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   logic clk;
   logic rst;

   logic       start8, c8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;

   logic       start4, c4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;

   logic       start1, c1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int checks;
   int failures;
   int ndone;
   int nbusy;
   int lat;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .c_in(c8),
      .busy(busy8), .done(done8), .sum_out(sum8), .c_out(cout8));

   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .c_in(c4),
      .busy(busy4), .done(done4), .sum_out(sum4), .c_out(cout4));

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .c_in(c1),
      .busy(busy1), .done(done1), .sum_out(sum1), .c_out(cout1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 addition from an idle cycle; returns in the following idle cycle.
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic ec);
      a8 = a; b8 = b; c8 = c; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 40) begin
         tick();
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd8);
      chk({tag, "_sum"}, 64'(sum8), 64'(es));
      chk({tag, "_cout"}, 64'(cout8), 64'(ec));
      tick();
   endtask

   task automatic run4(input int a, input int b, input int c);
      int s;
      s = a + b + c;
      a4 = 4'(a); b4 = 4'(b); c4 = c[0]; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 40) begin
         tick();
         lat++;
      end
      chk("w4_latency", 64'(lat), 64'd4);
      chk("w4_sum", 64'(sum4), 64'(s & 15));
      chk("w4_cout", 64'(cout4), 64'((s >> 4) & 1));
      tick();
   endtask

   task automatic run1(input int a, input int b, input int c);
      int s;
      s = a + b + c;
      a1 = 1'(a); b1 = 1'(b); c1 = c[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 40) begin
         tick();
         lat++;
      end
      chk("w1_latency", 64'(lat), 64'd1);
      chk("w1_sum", 64'(sum1), 64'(s & 1));
      chk("w1_cout", 64'(cout1), 64'((s >> 1) & 1));
      tick();
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_sum", 64'(sum8), 64'd0);
      chk("rst_cout", 64'(cout8), 64'd0);

      // 0x5A + 0x33: busy for cycles 1..8, done in cycle 9
      a8 = 8'h5A; b8 = 8'h33; c8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = '0; b8 = '0;
      for (int i = 0; i < 8; i++) begin
         chk("t1_busy", 64'(busy8), 64'd1);
         chk("t1_nodone", 64'(done8), 64'd0);
         chk("t1_nopartial", 64'(sum8), 64'd0);
         tick();
      end
      chk("t1_done", 64'(done8), 64'd1);
      chk("t1_busy_low", 64'(busy8), 64'd0);
      chk("t1_sum", 64'(sum8), 64'h8D);
      chk("t1_cout", 64'(cout8), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(done8), 64'd0);
      chk("t1_hold", 64'(sum8), 64'h8D);

      run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 20; i++) begin
         chk("hold_sum", 64'(sum8), 64'hFF);
         chk("hold_cout", 64'(cout8), 64'd1);
         tick();
      end

      // Start requests during RUN and DONE are dropped
      a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      ndone = 0;
      tick();
      tick();
      a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = '0; b8 = '0;
      repeat (5) begin
         if (done8) ndone++;
         tick();
      end
      chk("ign_done", 64'(done8), 64'd1);
      chk("ign_sum", 64'(sum8), 64'h30);
      chk("ign_cout", 64'(cout8), 64'd0);
      a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = '0; b8 = '0;
      nbusy = 0;
      repeat (20) begin
         if (done8) ndone++;
         if (busy8) nbusy++;
         tick();
      end
      chk("ign_extra_done", 64'(ndone), 64'd0);
      chk("ign_no_busy", 64'(nbusy), 64'd0);
      chk("ign_hold", 64'(sum8), 64'h30);

      // Reset at RUN cycle 4 aborts and clears the previous result
      a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 64'(busy8), 64'd0);
      chk("abort_done", 64'(done8), 64'd0);
      chk("abort_sum", 64'(sum8), 64'd0);
      chk("abort_cout", 64'(cout8), 64'd0);
      ndone = 0;
      repeat (15) begin
         if (done8) ndone++;
         tick();
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      run8("after_abort", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

      // Exhaustive back-to-back sweeps on the narrow builds
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               run4(a, b, c);

      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < 2; c++)
               run1(a, b, c);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
